pds_rx_port: RTL

Receive-side port of the packet switch. Samples 16-bit packet words (`{source[3:0], target[3:0], data[7:0]}`) presented on `data_ip`/`valid_up` by the input driver. It keeps only packets addressed to its own port number and buffers them in a small FIFO. It replays each packet on `data_op` with a `valid_op` pulse, so the output monitor sees exactly one rising edge of `valid_op` per packet.

---
 rtl/pds_pkg.sv | 27 ++
 rtl/pds_sync_fifo.sv | 43 ++++
 rtl/pds_rx_port.sv | 101 ++++++++++
 3 files changed

// File: rtl/pds_pkg.sv
// Shared definitions for the packet-switch receive port: packet field layout,
// packet word type and the receive FSM state encoding.
package pds_pkg;

    localparam int SRC_MSB  = 15;
    localparam int SRC_LSB  = 12;
    localparam int TGT_MSB  = 11;
    localparam int TGT_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;
    localparam int PORT_W   = 4;

    localparam logic [PORT_W-1:0] BCAST_TGT = 4'hF;

    typedef logic [15:0] pds_word_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } pds_rx_state_e;

    function automatic logic [PORT_W-1:0] pkt_target(input pds_word_t w);
        return w[TGT_MSB:TGT_LSB];
    endfunction

endpackage

// File: rtl/pds_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; an extra pointer bit tells
// full from empty, and the head word is read combinationally.
module pds_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/pds_rx_port.sv
// Receive port: filters packets by target, buffers them and replays each one
// with its own valid_op pulse. Define PDS_RX_BCAST_EN to accept target 4'hF.
module pds_rx_port
    import pds_pkg::*;
#(
    parameter logic [PORT_W-1:0] PORTNO = 4'd0,
    parameter int                DEPTH  = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  pds_word_t data_ip,
    input  logic      valid_up,
    input  logic      ready_op,
    output pds_word_t data_op,
    output logic      valid_op,
    output logic      full,
    output logic [7:0] drop_cnt
);

    pds_rx_state_e r_state;
    pds_word_t     r_data_op;
    logic          r_valid_op;
    logic [7:0]    r_drop_cnt;

    pds_word_t w_head;
    logic      w_empty;
    logic      w_full;
    logic      w_match;
    logic      w_pop;
    logic      w_accept;

`ifdef PDS_RX_BCAST_EN
    assign w_match = (pkt_target(data_ip) == PORTNO) || (pkt_target(data_ip) == BCAST_TGT);
`else
    assign w_match = (pkt_target(data_ip) == PORTNO);
`endif

    // A pop frees a slot on the same edge, so a full FIFO can still take a word.
    assign w_pop    = (r_state == IDLE) && !w_empty;
    assign w_accept = valid_up && w_match && (!w_full || w_pop);

    pds_sync_fifo #(
        .WIDTH ($bits(pds_word_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_data  (data_ip),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= 8'h00;
        end else if (valid_up && !w_accept && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // GAP forces valid_op low for a cycle so every packet gets a fresh rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_data_op  <= '0;
            r_valid_op <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_data_op  <= w_head;
                        r_valid_op <= 1'b1;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (ready_op) begin
                        r_valid_op <= 1'b0;
                        r_state    <= GAP;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_valid_op <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign data_op  = r_data_op;
    assign valid_op = r_valid_op;
    assign full     = w_full;
    assign drop_cnt = r_drop_cnt;

endmodule
